// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared defaults and state encoding for the DDR burst arbiter.
package ddr_arb_pkg;
  localparam int ADDR_W_DEF  = 25;
  localparam int LEN_W_DEF   = 10;
  localparam int TIMEOUT_DEF = 4096;
  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY, GAP} state_e;
endpackage

// File: rtl/burst_watchdog.sv
// burst_watchdog: counts busy cycles of a granted burst and flags the last allowed cycle.
module burst_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (clear) cnt_q <= '0;
    else if (enable) cnt_q <= cnt_q + CW'(1);
  end
  assign expired = enable && cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter: grants write/read bursts to the DDR controller with urgent-read priority,
// round-robin tie breaking, a one-cycle turnaround gap and a per-burst watchdog.
module ddr_burst_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ddr_init_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_finish,
  input  logic              rd_req,
  input  logic              rd_urgent,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_finish,
  output logic              ddr_wr_burst_req,
  output logic              ddr_rd_burst_req,
  output logic [ADDR_W-1:0] ddr_burst_addr,
  output logic [LEN_W-1:0]  ddr_burst_len,
  input  logic              ddr_wr_burst_finish,
  input  logic              ddr_rd_burst_finish,
  output logic              busy,
  output logic              err_timeout,
  output logic [15:0]       wr_burst_cnt,
  output logic [15:0]       rd_burst_cnt
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic              wr_fin_q, wr_fin_d, rd_fin_q, rd_fin_d;
  logic              err_q, err_d, last_wr_q, last_wr_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic              in_busy, fin, expired, pick_rd, grant_wr, grant_rd;

  assign in_busy  = state_q == WR_BUSY || state_q == RD_BUSY;
  assign fin      = (state_q == WR_BUSY && ddr_wr_burst_finish) || (state_q == RD_BUSY && ddr_rd_burst_finish);
  // Urgent read wins outright; otherwise the client not served last wins a tie.
  assign pick_rd  = rd_req && (rd_urgent || !wr_req || last_wr_q);
  assign grant_rd = state_q == IDLE && ddr_init_done && pick_rd;
  assign grant_wr = state_q == IDLE && ddr_init_done && wr_req && !pick_rd;

  burst_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_wr || grant_rd),
    .enable  (in_busy),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    wr_req_d  = wr_req_q;
    rd_req_d  = rd_req_q;
    wr_fin_d  = 1'b0;
    rd_fin_d  = 1'b0;
    err_d     = err_q;
    last_wr_d = last_wr_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    if (grant_wr || grant_rd) begin
      state_d  = grant_wr ? WR_BUSY : RD_BUSY;
      addr_d   = grant_wr ? wr_addr : rd_addr;
      len_d    = grant_wr ? wr_len : rd_len;
      wr_req_d = grant_wr;
      rd_req_d = grant_rd;
    end else if (in_busy && (fin || expired)) begin
      // A finish coinciding with expiry is treated as a normal completion.
      state_d   = GAP;
      wr_req_d  = 1'b0;
      rd_req_d  = 1'b0;
      wr_fin_d  = state_q == WR_BUSY;
      rd_fin_d  = state_q == RD_BUSY;
      last_wr_d = state_q == WR_BUSY;
      err_d     = err_q || !fin;
      wr_cnt_d  = wr_cnt_q + 16'(fin && state_q == WR_BUSY);
      rd_cnt_d  = rd_cnt_q + 16'(fin && state_q == RD_BUSY);
    end else if (state_q == GAP) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      wr_fin_q  <= 1'b0;
      rd_fin_q  <= 1'b0;
      err_q     <= 1'b0;
      last_wr_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wr_req_q  <= wr_req_d;
      rd_req_q  <= rd_req_d;
      wr_fin_q  <= wr_fin_d;
      rd_fin_q  <= rd_fin_d;
      err_q     <= err_d;
      last_wr_q <= last_wr_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  assign ddr_wr_burst_req = wr_req_q;
  assign ddr_rd_burst_req = rd_req_q;
  assign ddr_burst_addr   = addr_q;
  assign ddr_burst_len    = len_q;
  assign wr_finish        = wr_fin_q;
  assign rd_finish        = rd_fin_q;
  assign busy             = state_q != IDLE;
  assign err_timeout      = err_q;
  assign wr_burst_cnt     = wr_cnt_q;
  assign rd_burst_cnt     = rd_cnt_q;
endmodule

// File: doc/ddr_burst_arbiter.md
DDR_BURST_ARBITER -- requirements
Module: ddr_burst_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, DDR burst address width.
REQ-002 SHALL have parameter LEN_W, default 10, burst length width.
REQ-003 SHALL have parameter TIMEOUT, default 4096, max cycles a granted burst waits for finish.
REQ-004 SHALL have ports: clk  in  1  controller clock (phy clock domain); rst  in  1  reset. One clock; reset is asynchronous and active-high.
REQ-005 SHALL have ports: ddr_init_done  in  1  memory calibrated; arbitration is enabled only while high.
REQ-006 SHALL have write-client ports: wr_req  in  1; wr_addr  in  ADDR_W; wr_len  in  LEN_W; wr_finish  out  1  one-cycle burst-done pulse.
REQ-007 SHALL have read-client ports: rd_req  in  1; rd_urgent  in  1  read FIFO near empty; rd_addr  in  ADDR_W; rd_len  in  LEN_W; rd_finish  out  1  one-cycle pulse.
REQ-008 SHALL have controller-side ports: ddr_wr_burst_req  out  1; ddr_rd_burst_req  out  1; ddr_burst_addr  out  ADDR_W; ddr_burst_len  out  LEN_W; ddr_wr_burst_finish  in  1; ddr_rd_burst_finish  in  1.
REQ-009 SHALL have status ports: busy  out  1; err_timeout  out  1  sticky; wr_burst_cnt  out  16; rd_burst_cnt  out  16.

Function
REQ-010 SHALL implement states IDLE, WR_BUSY, RD_BUSY, GAP.
REQ-011 In IDLE with ddr_init_done=0, SHALL ignore all requests and stay in IDLE.
REQ-012 In IDLE, priority: rd_req&rd_urgent first; else if both requests are pending, grant the client not granted last (round-robin bit last_wr); else grant the single requester.
REQ-013 On grant, SHALL latch the winner's addr/len into ddr_burst_addr/ddr_burst_len and assert the matching ddr_*_burst_req on the next cycle (1-cycle request-to-req latency).
REQ-014 ddr_*_burst_req, addr and len SHALL stay stable until the matching ddr_*_burst_finish is sampled high.
REQ-015 Finish pulses on the non-active channel SHALL be ignored.
REQ-016 On the active finish: deassert req the same clock edge, pulse wr_finish/rd_finish for exactly one cycle on the following cycle, increment the matching counter (16-bit, wraps 0xFFFF->0), update last_wr, then enter GAP.
REQ-017 GAP SHALL last exactly one cycle (bus turnaround), then return to IDLE; minimum request-to-request spacing is therefore 3 cycles after a finish.
REQ-018 A timeout counter SHALL clear on entering a BUSY state and increment each BUSY cycle; on reaching TIMEOUT-1 without finish: drop req, set err_timeout, pulse the client finish, do not increment the burst counter, enter GAP.
REQ-019 err_timeout SHALL clear only on reset.
REQ-020 busy SHALL be high in WR_BUSY, RD_BUSY and GAP.
REQ-021 A finish arriving in the same cycle the timeout fires SHALL count as a normal finish (no error).
REQ-022 ddr_init_done falling mid-burst SHALL NOT abort the burst; it only blocks new grants.
REQ-023 wr_req/rd_req deasserting after grant SHALL NOT cancel the burst.

Reset
REQ-024 On rst high, state=IDLE; all req/finish outputs 0; addr/len 0; busy 0; err_timeout 0; counters 0; last_wr 0 (write wins the first tie).
REQ-025 Reset mid-burst SHALL drop ddr_*_burst_req asynchronously with no client finish pulse.

Structure
REQ-026 State encoding, ADDR_W/LEN_W defaults and the TIMEOUT default SHALL live in shared package ddr_arb_pkg.
REQ-027 The timeout counter SHALL be a sub-module burst_watchdog (clear, enable, expired).

Verification
REQ-028 Tie: wr_req=rd_req=1 from reset, init_done=1 -> write granted first, then read; finish pulses alternate W,R,W,R.
REQ-029 Urgent: write pending, rd_req=1 with rd_urgent=1 in IDLE -> ddr_rd_burst_req next cycle, addr=rd_addr, len=rd_len (e.g. 48).
REQ-030 Timeout: TIMEOUT=16, no finish -> req drops after 16 BUSY cycles, err_timeout=1, wr_finish pulses once, wr_burst_cnt unchanged.
REQ-031 Init gating: requests while ddr_init_done=0 -> no req output; raise init_done -> grant on next cycle.
REQ-032 Counter wrap: force 65536 completed write bursts -> wr_burst_cnt returns to 0.
REQ-033 Reset mid-burst: rst during RD_BUSY -> ddr_rd_burst_req 0 immediately, no rd_finish, state IDLE.
